// File: rtl/lc3b_types.sv
// Shared LC-3b types for the branch resolve queue.
// Optional feature macro: BRQ_PC_CHECK_EN adds the per-entry pc field.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    localparam int BRQ_DEPTH = 4;

    // Fixed-width part of a queue entry; the GHR snapshot is carried
    // alongside it because its width is a module parameter.
    typedef struct packed {
`ifdef BRQ_PC_CHECK_EN
        lc3b_word pc;
`endif
        logic     lc_taken;
        logic     gl_taken;
        logic     pred_select;
    } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue_storage.sv
// brq_storage: DEPTH-entry register array, one write port, one
// asynchronous read port. Contents are not reset.
module brq_storage #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Write the addressed entry on an accepted push.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order FIFO of predicted branches awaiting
// resolution in WB. Produces predictor-correctness, mispredict and GHR
// restore value combinationally from the head entry.
// Optional feature macro: BRQ_PC_CHECK_EN (stores pc per entry and adds
// the sticky pc_mismatch_err output).
module branch_resolve_queue
    import lc3b_types::*;
#(
    parameter int DEPTH = BRQ_DEPTH,
    parameter int GHR_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       if_push,
    input  lc3b_word                   if_pc,
    input  logic                       if_lc_taken,
    input  logic                       if_gl_taken,
    input  logic                       if_pred_select,
    input  logic [GHR_W-1:0]           if_ghr,
    input  logic                       wbisbranch,
    input  logic                       wb_taken,
    input  lc3b_word                   wb_pcplus2,
    input  logic                       ext_flush,
    output logic                       lc_pred_correct,
    output logic                       gl_pred_correct,
    output logic                       mispredict,
    output logic [GHR_W-1:0]           ghr_restore,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf_err,
`ifdef BRQ_PC_CHECK_EN
    output logic                       unf_err,
    output logic                       pc_mismatch_err
`else
    output logic                       unf_err
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = $bits(brq_entry_t) + GHR_W;

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic             unf_q;

    brq_entry_t       new_ent;
    brq_entry_t       head_ent;
    logic [GHR_W-1:0] head_ghr;
    logic [ENT_W-1:0] wr_data;
    logic [ENT_W-1:0] rd_data;

    logic             resolve;
    logic             push_ok;
    logic             flush_all;
    logic             sel_dir;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

    // Pack the incoming prediction into an entry.
    always_comb begin
        new_ent             = '0;
`ifdef BRQ_PC_CHECK_EN
        new_ent.pc          = if_pc;
`endif
        new_ent.lc_taken    = if_lc_taken;
        new_ent.gl_taken    = if_gl_taken;
        new_ent.pred_select = if_pred_select;
    end

    assign wr_data  = {if_ghr, new_ent};
    assign head_ent = rd_data[$bits(brq_entry_t)-1:0];
    assign head_ghr = rd_data[ENT_W-1:$bits(brq_entry_t)];

    brq_storage #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_storage (
        .clk     (clk),
        .wr_en   (push_ok),
        .wr_addr (tail_q),
        .wr_data (wr_data),
        .rd_addr (head_q),
        .rd_data (rd_data)
    );

    // Resolve-qualified correctness outputs and queue control decisions.
    always_comb begin
        resolve         = wbisbranch & ~empty;
        sel_dir         = head_ent.pred_select ? head_ent.gl_taken : head_ent.lc_taken;
        lc_pred_correct = resolve & (head_ent.lc_taken == wb_taken);
        gl_pred_correct = resolve & (head_ent.gl_taken == wb_taken);
        mispredict      = resolve & (sel_dir != wb_taken);
        ghr_restore     = resolve ? {head_ghr[GHR_W-2:0], wb_taken} : '0;
        // A mispredict or external flush kills everything, including a
        // same-cycle push which is on the wrong path.
        flush_all       = ext_flush | mispredict;
        push_ok         = if_push & ~full & ~flush_all;
    end

    // Head/tail pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_all) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (resolve) head_q <= head_q + PTR_W'(1);
            if (push_ok) tail_q <= tail_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(resolve);
        end
    end

    // Sticky overflow/underflow flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (if_push && full)     ovf_q <= 1'b1;
            if (wbisbranch && empty) unf_q <= 1'b1;
        end
    end

`ifdef BRQ_PC_CHECK_EN
    logic pcm_q;
    assign pc_mismatch_err = pcm_q;

    // Sticky flag: the resolving branch is not the one at the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pcm_q <= 1'b0;
        else if (resolve && ((wb_pcplus2 - 16'd2) != head_ent.pc)) pcm_q <= 1'b1;
    end
`else
    logic unused_pc;
    assign unused_pc = ^{if_pc, wb_pcplus2};
`endif

endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning in-flight branch entries; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL have parameter GHR_W, default 8, meaning the width of the global-history snapshot.
REQ-003 The block SHALL have these ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_push  in  1  predicted branch leaves IF.
- if_pc  in  16  lc3b_word; PC of that branch.
- if_lc_taken  in  1  local predictor direction.
- if_gl_taken  in  1  global predictor direction.
- if_pred_select  in  1  choice selection; 1 = global.
- if_ghr  in  GHR_W  history snapshot at prediction time.
- wbisbranch  in  1  branch resolves in WB this cycle.
- wb_taken  in  1  actual direction.
- wb_pcplus2  in  16  lc3b_word; resolving branch PC+2.
- ext_flush  in  1  discard all entries (trap/interrupt).
- lc_pred_correct  out  1  local prediction matched wb_taken.
- gl_pred_correct  out  1  global prediction matched wb_taken.
- mispredict  out  1  selected prediction wrong.
- ghr_restore  out  GHR_W  head snapshot shifted left with wb_taken in bit 0.
- full, empty  out  1 each  occupancy status.
- count  out  clog2(DEPTH)+1  occupancy.
- ovf_err, unf_err  out  1 each  sticky overflow and underflow flags.

Function
REQ-004 The queue SHALL be a circular FIFO with head pointer, tail pointer and count; each entry SHALL hold pc, lc_taken, gl_taken, pred_select and ghr.
REQ-005 A push SHALL write the tail entry and advance tail at the clock edge when if_push=1 and full=0.
REQ-006 A resolve SHALL occur when wbisbranch=1 and empty=0; it SHALL advance head at the clock edge.
REQ-007 lc_pred_correct, gl_pred_correct, mispredict and ghr_restore SHALL be combinational from the head entry and wb_taken, with zero-cycle latency, and SHALL be qualified by a resolve; outside a resolve they SHALL be 0.
REQ-008 The selected direction SHALL be gl_taken when pred_select=1 and lc_taken otherwise; mispredict SHALL be (selected direction != wb_taken).
REQ-009 On a resolve with mispredict=1, all entries SHALL be discarded at that edge (count=0, head=tail), and a same-cycle push SHALL be dropped as wrong-path.
REQ-010 ext_flush=1 SHALL discard all entries and any same-cycle push; a same-cycle resolve SHALL still produce its outputs.
REQ-011 A simultaneous push and resolve without mispredict SHALL leave count unchanged.
REQ-012 Pointers SHALL wrap modulo DEPTH.
REQ-013 full SHALL be (count==DEPTH) and empty SHALL be (count==0).
REQ-014 if_push with full=1 SHALL be dropped and SHALL set ovf_err.
REQ-015 wbisbranch with empty=1 SHALL be ignored and SHALL set unf_err.

Reset
REQ-016 rst_n=0 SHALL asynchronously clear both pointers, count, ovf_err and unf_err; empty SHALL be 1 and all other outputs 0.
REQ-017 Entry storage SHALL need no reset.
REQ-018 Reset asserted mid-operation SHALL discard all entries immediately.

Configuration
REQ-019 With BRQ_PC_CHECK_EN defined, the block SHALL store pc per entry and add output pc_mismatch_err (sticky, 1 bit), set when a resolve's (wb_pcplus2 - 2) differs from the head pc.
REQ-020 Without BRQ_PC_CHECK_EN, the pc field and pc_mismatch_err SHALL be absent and if_pc and wb_pcplus2 SHALL be unused.

Structure
REQ-021 The brq_entry_t struct and the BRQ_DEPTH default SHALL live in lc3b_types.
REQ-022 There SHALL be one sub-module, brq_storage, a DEPTH-entry register array with a single write port and a single read port.

Verification
REQ-023 Reset, push pc=0x3000 with lc=1, gl=0, sel=0, then resolve wb_taken=1 -> lc_pred_correct=1, gl_pred_correct=0, mispredict=0, count 1->0.
REQ-024 Push 4 with DEPTH=4, then a 5th push -> full=1, ovf_err=1, count=4, and the 5th entry is never resolved.
REQ-025 Push 3, resolve the head with sel=1, gl=1, wb_taken=0 while pushing -> mispredict=1, and count=0 and empty=1 on the next cycle.
REQ-026 Resolve while empty -> all correctness outputs 0, unf_err=1, pointers unchanged.
REQ-027 Push 2 and resolve 1 in the same cycle repeatedly for 10 cycles -> count steady, wrap-around correct, ghr_restore = {ghr[GHR_W-2:0], wb_taken}.
REQ-028 With BRQ_PC_CHECK_EN defined, push pc 0x3000, then resolve with wb_pcplus2=0x3004 -> pc_mismatch_err=1.
